fp_add_seq: RTL and testbench
=============================

FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 The module SHALL have parameter EXP_W, default 8, meaning the biased exponent width.
REQ-002 The module SHALL have parameter FRAC_W, default 23, meaning the stored fraction width, with an implicit hidden bit.
REQ-003 Clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 ResetN  input  1  reset, asynchronous and active-low.
REQ-005 InValid  input  1  an operand pair is offered.
REQ-006 InReady  output  1  the block accepts operands.
REQ-007 OpA, OpB  input  1+EXP_W+FRAC_W  operands, packed as {sign, biased exp, fraction}.
REQ-008 OutValid  output  1  Result is valid.
REQ-009 OutReady  input  1  the consumer accepts Result.
REQ-010 Result  output  1+EXP_W+FRAC_W  sum, in the same packing as the operands.
REQ-011 Overflow  output  1  the result exponent saturated; valid while OutValid is high.

Function
REQ-012 The FSM SHALL have the states IDLE, ALIGN, ADD, NORM and DONE.
REQ-013 IDLE: InReady=1. On InValid&&InReady the block SHALL capture the operands and go to ALIGN; otherwise it stays in IDLE.
REQ-014 Capture: an exponent field of 0 SHALL mean the value zero (hidden bit 0; no denormals). Any other exponent SHALL have hidden bit 1. Infinity and NaN SHALL NOT be handled.
REQ-015 Capture: the exponent compare SHALL determine big/small, and the operand with exp A >= exp B SHALL be big (tie: A is big). ShiftCnt SHALL equal the exponent difference, saturated at FRAC_W+2.
REQ-016 ALIGN: if ShiftCnt==0, go to ADD; otherwise shift the small mantissa right by 1 and decrement ShiftCnt, one bit per cycle. Shifted-out bits SHALL be truncated.
REQ-017 ADD: mantissas SHALL be FRAC_W+2 bits wide (carry plus hidden bit).
- Equal signs: add the mantissas; the result sign is the big sign.
- Differing signs: subtract the smaller mantissa magnitude from the larger; the result sign is the sign of the larger magnitude.
- The next state SHALL be NORM.
REQ-018 NORM, evaluated in priority order:
- Carry bit set: shift right 1, exponent+1, go to DONE.
- Mantissa zero: Result=+0 (all zeros), go to DONE.
- Hidden bit clear: shift left 1 and exponent-1 per cycle. If the exponent reaches 0, flush Result to +0 and go to DONE.
- Hidden bit set: go to DONE.
REQ-019 If the exponent reaches all-ones, Result SHALL be {sign, all-ones, 0} and Overflow=1.
REQ-020 DONE: OutValid=1 and InReady=0. Result and Overflow SHALL be held stable until OutReady; on OutValid&&OutReady the block SHALL go to IDLE.
REQ-021 InValid outside IDLE SHALL be ignored. There is no bypass from DONE to accept: a new operand pair is accepted no earlier than the cycle after the DONE handshake.
REQ-022 Latency SHALL be 4 cycles plus ShiftCnt plus the number of left-normalize cycles. The count runs from the accept edge to the first cycle with OutValid high.
REQ-023 OutValid SHALL be 0 in every state except DONE. Result and Overflow SHALL hold their last values outside DONE.

Reset
REQ-024 ResetN low SHALL immediately force IDLE, InReady=1, OutValid=0, Result=0, Overflow=0, and clear all internal registers.
REQ-025 Reset asserted in any state, including mid-ALIGN or mid-NORM, SHALL abort the operation with no output handshake.

Structure
REQ-026 The package fp_add_pkg SHALL hold the following, and the FSM SHALL use the package state type:
- the FSM state enum;
- the width localparams (WORD_W, MANT_W = FRAC_W+2);
- a packed struct typedef {sign, exp, frac}.
REQ-027 The exponent compare and difference SHALL come from one instantiated sub-module, ExpALU (ExpA, ExpB -> ExpSet, ExpDiff), with no duplicate logic.

Verification (EXP_W=8, FRAC_W=23)
REQ-028 1.0+1.0: 0x3F800000 + 0x3F800000 -> Result 0x40000000, Overflow 0, OutValid first high 4 cycles after accept.
REQ-029 1.0+0.5: 0x3F800000 + 0x3F000000 -> Result 0x3FC00000, one ALIGN shift, OutValid at cycle 5.
REQ-030 1.0 + (-1.0): 0x3F800000 + 0xBF800000 -> Result 0x00000000.
REQ-031 Overflow: 0x7F000000 + 0x7F000000 -> Result 0x7F800000, Overflow 1.
REQ-032 Backpressure: hold OutReady=0 for 5 cycles in DONE -> Result stable, InReady 0, InValid ignored; release OutReady -> IDLE next cycle.
REQ-033 Reset mid-op: deassert ResetN during ALIGN of 0x4B000000 + 0x3F800000 (diff 23) -> OutValid 0, InReady 1, Result 0 immediately; the next operation completes correctly.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and widths for the sequential floating-point adder.
package fp_add_pkg;

  // Default operand format (IEEE-754 single precision layout).
  localparam int DEF_EXP_W  = 8;
  localparam int DEF_FRAC_W = 23;

  // Packed operand width and working mantissa width (carry + hidden + fraction).
  localparam int WORD_W = 1 + DEF_EXP_W + DEF_FRAC_W;
  localparam int MANT_W = DEF_FRAC_W + 2;

  // Controller states: capture, align the smaller operand, add, normalize, present.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Field view of a packed operand in the default format.
  typedef struct packed {
    logic                  sign;
    logic [DEF_EXP_W-1:0]  exp;
    logic [DEF_FRAC_W-1:0] frac;
  } fp_word_t;

endpackage

// File: rtl/fp_add_exp_alu.sv
// Exponent comparator: reports which exponent is larger and their magnitude difference.
module fp_add_exp_alu #(
  parameter int EXP_W = 8
) (
  input  logic [EXP_W-1:0] ExpA,
  input  logic [EXP_W-1:0] ExpB,
  output logic             ExpSet,
  output logic [EXP_W-1:0] ExpDiff
);

  // ExpSet means A is the big operand (ties favour A); ExpDiff is always non-negative.
  always_comb begin
    ExpSet  = 1'b0;
    ExpDiff = {EXP_W{1'b0}};
    if (ExpA >= ExpB) begin
      ExpSet  = 1'b1;
      ExpDiff = ExpA - ExpB;
    end else begin
      ExpSet  = 1'b0;
      ExpDiff = ExpB - ExpA;
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder: one-bit-per-cycle alignment and normalization,
// valid/ready handshakes on both sides, no denormal/Inf/NaN support.
module fp_add_seq
  import fp_add_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [EXP_W+FRAC_W:0]     OpA,
  input  logic [EXP_W+FRAC_W:0]     OpB,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [EXP_W+FRAC_W:0]     Result,
  output logic                      Overflow
);

  localparam int OP_W  = 1 + EXP_W + FRAC_W;
  localparam int SUM_W = FRAC_W + 2;
  localparam int SAT   = FRAC_W + 2;
  localparam int CNT_W = $clog2(SAT + 1);

  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [SUM_W-1:0] MANT_ZERO = {SUM_W{1'b0}};

  // Registered state
  state_t           state_r,      state_s;
  logic             big_sign_r,   big_sign_s;
  logic             small_sign_r, small_sign_s;
  logic [EXP_W-1:0] exp_r,        exp_s;
  logic [SUM_W-1:0] big_mant_r,   big_mant_s;
  logic [SUM_W-1:0] small_mant_r, small_mant_s;
  logic [CNT_W-1:0] shift_cnt_r,  shift_cnt_s;
  logic [OP_W-1:0]  result_r,     result_s;
  logic             overflow_r,   overflow_s;

  // Operand decode
  logic [EXP_W-1:0]  exp_a_s, exp_b_s;
  logic [SUM_W-1:0]  mant_a_s, mant_b_s;
  logic              a_big_s;
  logic [EXP_W-1:0]  exp_diff_s;
  logic [31:0]       diff_wide_s;
  logic [CNT_W-1:0]  shift_init_s;
  logic [EXP_W-1:0]  exp_inc_s, exp_dec_s;

  assign exp_a_s  = OpA[OP_W-2 -: EXP_W];
  assign exp_b_s  = OpB[OP_W-2 -: EXP_W];
  // A zero exponent encodes zero: the whole mantissa, hidden bit included, is cleared.
  assign mant_a_s = (exp_a_s == EXP_ZERO) ? MANT_ZERO : {2'b01, OpA[FRAC_W-1:0]};
  assign mant_b_s = (exp_b_s == EXP_ZERO) ? MANT_ZERO : {2'b01, OpB[FRAC_W-1:0]};

  fp_add_exp_alu #(.EXP_W(EXP_W)) exp_alu (
    .ExpA   (exp_a_s),
    .ExpB   (exp_b_s),
    .ExpSet (a_big_s),
    .ExpDiff(exp_diff_s)
  );

  // Shifting past the full mantissa width only wastes cycles, so the count saturates.
  assign diff_wide_s  = 32'(exp_diff_s);
  assign shift_init_s = (diff_wide_s > 32'(SAT)) ? CNT_W'(SAT) : CNT_W'(diff_wide_s);

  assign exp_inc_s = exp_r + EXP_ONE;
  assign exp_dec_s = exp_r - EXP_ONE;

  assign InReady  = (state_r == IDLE);
  assign OutValid = (state_r == DONE);
  assign Result   = result_r;
  assign Overflow = overflow_r;

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_s      = state_r;
    big_sign_s   = big_sign_r;
    small_sign_s = small_sign_r;
    exp_s        = exp_r;
    big_mant_s   = big_mant_r;
    small_mant_s = small_mant_r;
    shift_cnt_s  = shift_cnt_r;
    result_s     = result_r;
    overflow_s   = overflow_r;
    case (state_r)
      IDLE: begin
        if (InValid) begin
          shift_cnt_s = shift_init_s;
          state_s     = ALIGN;
          if (a_big_s) begin
            big_sign_s   = OpA[OP_W-1];
            small_sign_s = OpB[OP_W-1];
            exp_s        = exp_a_s;
            big_mant_s   = mant_a_s;
            small_mant_s = mant_b_s;
          end else begin
            big_sign_s   = OpB[OP_W-1];
            small_sign_s = OpA[OP_W-1];
            exp_s        = exp_b_s;
            big_mant_s   = mant_b_s;
            small_mant_s = mant_a_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ALIGN: begin
        if (shift_cnt_r == CNT_ZERO) begin
          state_s = ADD;
        end else begin
          small_mant_s = {1'b0, small_mant_r[SUM_W-1:1]};
          shift_cnt_s  = shift_cnt_r - CNT_ONE;
        end
      end
      ADD: begin
        state_s = NORM;
        if (big_sign_r == small_sign_r) begin
          big_mant_s = big_mant_r + small_mant_r;
        end else if (big_mant_r >= small_mant_r) begin
          big_mant_s = big_mant_r - small_mant_r;
        end else begin
          big_mant_s = small_mant_r - big_mant_r;
          big_sign_s = small_sign_r;
        end
      end
      NORM: begin
        if (big_mant_r[SUM_W-1]) begin
          state_s = DONE;
          if (exp_inc_s == EXP_ONES) begin
            result_s   = {big_sign_r, EXP_ONES, {FRAC_W{1'b0}}};
            overflow_s = 1'b1;
          end else begin
            result_s   = {big_sign_r, exp_inc_s, big_mant_r[FRAC_W:1]};
            overflow_s = 1'b0;
          end
        end else if (big_mant_r == MANT_ZERO) begin
          state_s    = DONE;
          result_s   = {OP_W{1'b0}};
          overflow_s = 1'b0;
        end else if (!big_mant_r[FRAC_W]) begin
          big_mant_s = {big_mant_r[SUM_W-2:0], 1'b0};
          exp_s      = exp_dec_s;
          if (exp_dec_s == EXP_ZERO) begin
            state_s    = DONE;
            result_s   = {OP_W{1'b0}};
            overflow_s = 1'b0;
          end else begin
            state_s = NORM;
          end
        end else begin
          state_s    = DONE;
          result_s   = {big_sign_r, exp_r, big_mant_r[FRAC_W-1:0]};
          overflow_s = 1'b0;
        end
      end
      DONE: begin
        if (OutReady) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with asynchronous clear of every register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r      <= IDLE;
      big_sign_r   <= 1'b0;
      small_sign_r <= 1'b0;
      exp_r        <= EXP_ZERO;
      big_mant_r   <= MANT_ZERO;
      small_mant_r <= MANT_ZERO;
      shift_cnt_r  <= CNT_ZERO;
      result_r     <= {OP_W{1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      big_sign_r   <= big_sign_s;
      small_sign_r <= small_sign_s;
      exp_r        <= exp_s;
      big_mant_r   <= big_mant_s;
      small_mant_r <= small_mant_s;
      shift_cnt_r  <= shift_cnt_s;
      result_r     <= result_s;
      overflow_r   <= overflow_s;
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: the driver queues expected results at accept,
// a negedge monitor checks them whenever the adder presents an output.
module tb_fp_add_seq;

  logic        Clock    = 1'b0;
  logic        ResetN   = 1'b0;
  logic        InValid  = 1'b0;
  logic        OutReady = 1'b1;
  logic [31:0] OpA      = 32'h0;
  logic [31:0] OpB      = 32'h0;
  logic        InReady;
  logic        OutValid;
  logic [31:0] Result;
  logic        Overflow;

  fp_add_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .InValid (InValid),
    .InReady (InReady),
    .OpA     (OpA),
    .OpB     (OpB),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Result  (Result),
    .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;   // -1: latency not checked
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   acc_cyc = 0;
  bit   was_valid = 1'b0;
  bit   post_hs   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: compare each presented output against the oldest expected entry.
  always @(negedge Clock) begin
    if (!ResetN) begin
      was_valid = 1'b0;
      post_hs   = 1'b0;
    end else begin
      if (post_hs) begin
        check("idle_after_handshake_inready", 32'(InReady), 32'd1);
        check("idle_after_handshake_outvalid", 32'(OutValid), 32'd0);
        post_hs = 1'b0;
      end
      if (InValid && InReady) acc_cyc = cyc + 1;
      if (OutValid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %h, expected no output", Result);
        end else begin
          if (!was_valid && sb[0].lat >= 0)
            check("latency", 32'(cyc - acc_cyc + 1), 32'(sb[0].lat));
          check("inready_in_done", 32'(InReady), 32'd0);
          check("result", Result, sb[0].res);
          check("overflow", 32'(Overflow), 32'(sb[0].ovf));
          if (OutReady) begin
            void'(sb.pop_front());
            post_hs = 1'b1;
          end
        end
      end
      was_valid = OutValid && !OutReady;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                      input logic ovf, input int lat, input bit push);
    bit   ok = 1'b0;
    exp_t e;
    @(posedge Clock); #1;
    InValid = 1'b1; OpA = a; OpB = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (InReady) begin
        if (push) begin
          e.res = res; e.ovf = ovf; e.lat = lat;
          sb.push_back(e);
        end
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: got InReady %b, expected 1", InReady);
    end
    @(posedge Clock); #1;
    InValid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clock); #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL done_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t vecs[9] = '{
    '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 4},   // 1 + 1
    '{32'h3F800000, 32'h3F000000, 32'h3FC00000, 1'b0, 5},   // 1 + 0.5
    '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 4},   // 1 - 1
    '{32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 5},   // 3 - 1
    '{32'h3FC00000, 32'hBFA00000, 32'h3E800000, 1'b0, 6},   // 1.5 - 1.25, two left shifts
    '{32'h00000000, 32'h40200000, 32'h40200000, 1'b0, 29},  // 0 + 2.5, shift saturates at 25
    '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 28},  // 1 + 2^-24, truncated away
    '{32'h00800000, 32'h80C00000, 32'h00000000, 1'b0, -1},  // underflow flush to +0
    '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 4}    // exponent overflow
  };

  initial begin
    bit seen;
    ResetN = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    check("reset_inready", 32'(InReady), 32'd1);
    check("reset_outvalid", 32'(OutValid), 32'd0);
    check("reset_result", Result, 32'h0);
    check("reset_overflow", 32'(Overflow), 32'd0);
    @(posedge Clock); #1;
    ResetN = 1'b1;

    // Backpressure: hold the result in DONE while offering a new pair that must be ignored.
    OutReady = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 4, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (OutValid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL backpressure_outvalid_timeout: got OutValid %b, expected 1", OutValid);
    end
    @(posedge Clock); #1;
    InValid = 1'b1; OpA = 32'h40400000; OpB = 32'h40400000;
    repeat (5) @(posedge Clock);
    #1;
    InValid  = 1'b0;
    OutReady = 1'b1;
    wait_done();
    repeat (10) @(posedge Clock);

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].lat, 1'b1);
      wait_done();
    end

    // Reset in the middle of a 23-step alignment: no output, everything cleared at once.
    send(32'h4B000000, 32'h3F800000, 32'h0, 1'b0, -1, 1'b0);
    repeat (5) @(posedge Clock);
    #2;
    ResetN = 1'b0;
    #1;
    check("midreset_outvalid", 32'(OutValid), 32'd0);
    check("midreset_inready", 32'(InReady), 32'd1);
    check("midreset_result", Result, 32'h0);
    check("midreset_overflow", 32'(Overflow), 32'd0);
    @(posedge Clock); #1;
    ResetN = 1'b1;
    send(32'h4B000000, 32'h3F800000, 32'h4B000001, 1'b0, 27, 1'b1);
    wait_done();
    repeat (5) @(posedge Clock);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
